caixa_nivel_ctrl: RTL and testbench

Parametrised tank-level controller for the irrigation system's water tank. It debounces N level sensors and checks that the debounced readings are physically consistent (a thermometer code). It drives the inlet valve with hysteresis, supervises filling with a no-progress timeout, and raises a latched alarm on sensor inconsistency or fill failure. It sits between the raw tank sensors and the valve/alarm outputs, and is the generalised successor of the fixed three-sensor combinational error check.

---
 rtl/caixa_pkg.sv | 53 +++++
 rtl/sensor_debounce.sv | 34 +++
 rtl/caixa_nivel_ctrl.sv | 108 ++++++++++
 tb/tb_caixa_nivel_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/caixa_pkg.sv
// Shared types and helpers for the tank-level controller: FSM state encoding,
// thermometer-code validity and level decode, and width helpers.
package caixa_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ENCHENDO = 2'd1,
    FALHA    = 2'd2
  } estado_t;

  // Helpers take a fixed-width vector; callers zero-extend their sensor bus.
  localparam int MAX_SENSORES = 32;

  function automatic int largura_nivel(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of a counter that must hold values 0..n-1.
  function automatic int largura_cont(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Valid when no set bit sits above a cleared one within the low n bits.
  function automatic logic eh_termometro(input logic [MAX_SENSORES-1:0] v, input int n);
    logic zero_visto;
    logic ok;
    zero_visto = 1'b0;
    ok         = 1'b1;
    for (int i = 0; i < MAX_SENSORES; i++) begin
      if (i < n) begin
        if (!v[i]) zero_visto = 1'b1;
        else if (zero_visto) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Number of consecutive ones counted up from bit 0.
  function automatic int nivel_termometro(input logic [MAX_SENSORES-1:0] v, input int n);
    int  nivel;
    logic continua;
    nivel    = 0;
    continua = 1'b1;
    for (int i = 0; i < MAX_SENSORES; i++) begin
      if (i < n) begin
        if (continua && v[i]) nivel = i + 1;
        else continua = 1'b0;
      end
    end
    return nivel;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One-bit debouncer: the output follows the raw input only after
// DEBOUNCE_CICLOS consecutive mismatching samples.
module sensor_debounce
  import caixa_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = 4
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic bruto,
  output logic deb
);

  localparam int CW = largura_cont(DEBOUNCE_CICLOS);

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (bruto != deb) begin
      if (cnt == CW'(DEBOUNCE_CICLOS - 1)) begin
        deb <= bruto;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/caixa_nivel_ctrl.sv
// Tank-level controller: debounced level sensors, consistency check, latched
// measurement error, and the inlet-valve fill FSM with a no-progress timeout.
module caixa_nivel_ctrl
  import caixa_pkg::*;
#(
  parameter int N_SENSORES      = 3,
  parameter int DEBOUNCE_CICLOS = 4,
  parameter int NIVEL_LIGA      = 1,
  parameter int TIMEOUT_ENCHER  = 1024
) (
  input  logic                              Clk,
  input  logic                              Rst_n,
  input  logic [N_SENSORES-1:0]             Sensores,
  input  logic                              Ack_Erro,
  output logic [$clog2(N_SENSORES+1)-1:0]   Nivel,
  output logic                              ErroMedida,
  output logic                              VEntrada,
  output logic                              Alarme,
  output logic [1:0]                        Estado
);

  // state    | meaning
  // OCIOSO   | valve closed, waiting for level to drop below NIVEL_LIGA
  // ENCHENDO | valve open, watching for level progress or a full tank
  // FALHA    | alarm; waits for operator ack with a consistent sensor vector

  localparam int NW = largura_nivel(N_SENSORES);
  localparam int TW = largura_cont(TIMEOUT_ENCHER);

  logic [N_SENSORES-1:0] deb;
  logic [NW-1:0]         nivel;
  logic [NW-1:0]         nivel_ant;
  logic                  invalido;
  logic                  erro, erro_prox;
  estado_t               estado, estado_prox;
  logic [TW-1:0]         cnt_to, cnt_to_prox;

  for (genvar g = 0; g < N_SENSORES; g++) begin : g_deb
    sensor_debounce #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_deb (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bruto (Sensores[g]),
      .deb   (deb[g])
    );
  end

  assign invalido = !eh_termometro(MAX_SENSORES'(deb), N_SENSORES);
  assign nivel    = NW'(nivel_termometro(MAX_SENSORES'(deb), N_SENSORES));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      estado    <= OCIOSO;
      cnt_to    <= '0;
      nivel_ant <= '0;
      erro      <= 1'b0;
    end else begin
      estado    <= estado_prox;
      cnt_to    <= cnt_to_prox;
      nivel_ant <= nivel;
      erro      <= erro_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    cnt_to_prox = '0;
    erro_prox   = erro;

    // An invalid vector sets the latch even when ack is present.
    if (invalido)      erro_prox = 1'b1;
    else if (Ack_Erro) erro_prox = 1'b0;

    case (estado)
      OCIOSO: begin
        if (nivel < NW'(NIVEL_LIGA)) estado_prox = ENCHENDO;
      end
      ENCHENDO: begin
        if (nivel == NW'(N_SENSORES)) begin
          estado_prox = OCIOSO;
        end else if (nivel > nivel_ant) begin
          cnt_to_prox = '0;
        end else if (cnt_to == TW'(TIMEOUT_ENCHER - 1)) begin
          estado_prox = FALHA;
        end else begin
          cnt_to_prox = cnt_to + 1'b1;
        end
      end
      FALHA: begin
        if (Ack_Erro && !invalido) estado_prox = OCIOSO;
      end
      default: estado_prox = OCIOSO;
    endcase

    if (invalido) begin
      estado_prox = FALHA;
      cnt_to_prox = '0;
    end
  end

  assign Nivel      = nivel;
  assign ErroMedida = erro;
  assign Estado     = estado;
  assign VEntrada   = (estado == ENCHENDO);
  assign Alarme     = (estado == FALHA);

endmodule

// File: tb/tb_caixa_nivel_ctrl.sv
// Directed bench for caixa_nivel_ctrl (N=3, debounce 4, liga 1, timeout 16).
module tb_caixa_nivel_ctrl;

  logic       Clk;
  logic       Rst_n;
  logic [2:0] Sensores;
  logic       Ack_Erro;
  logic [1:0] Nivel;
  logic       ErroMedida;
  logic       VEntrada;
  logic       Alarme;
  logic [1:0] Estado;

  int checks = 0;
  int erros  = 0;

  caixa_nivel_ctrl #(
    .N_SENSORES      (3),
    .DEBOUNCE_CICLOS (4),
    .NIVEL_LIGA      (1),
    .TIMEOUT_ENCHER  (16)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Sensores   (Sensores),
    .Ack_Erro   (Ack_Erro),
    .Nivel      (Nivel),
    .ErroMedida (ErroMedida),
    .VEntrada   (VEntrada),
    .Alarme     (Alarme),
    .Estado     (Estado)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] sens;
    logic       ack;
    int         ciclos;
    int         nivel;
    int         erro;
    int         estado;
  } vetor_t;

  vetor_t tab[$];

  function automatic vetor_t v(input logic [2:0] s, input logic a, input int c,
                               input int n, input int e, input int st);
    vetor_t r;
    r.sens = s; r.ack = a; r.ciclos = c; r.nivel = n; r.erro = e; r.estado = st;
    return r;
  endfunction

  task automatic verif(input string nome, input int atual, input int esp);
    checks++;
    if (atual != esp) begin
      erros++;
      $display("FAIL %s: got %0d expected %0d", nome, atual, esp);
    end
  endtask

  task automatic passo(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic reinicia();
    Rst_n = 1'b0; Sensores = 3'b000; Ack_Erro = 1'b0;
    passo(2);
    Rst_n = 1'b1;
  endtask

  task automatic verif_todos(input string nome, input int n, input int e, input int st);
    verif({nome, " nivel"},  int'(Nivel), n);
    verif({nome, " erro"},   int'(ErroMedida), e);
    verif({nome, " estado"}, int'(Estado), st);
    verif({nome, " valvula"}, int'(VEntrada), (st == 1) ? 1 : 0);
    verif({nome, " alarme"},  int'(Alarme), (st == 2) ? 1 : 0);
  endtask

  initial begin
    Rst_n = 1'b0; Sensores = 3'b000; Ack_Erro = 1'b0;

    // sens, ack, cycles -> nivel, erro, estado (sampled 1 unit after last edge)
    tab.push_back(v(3'b000, 0, 1, 0, 0, 1));  // first edge after release
    tab.push_back(v(3'b001, 0, 3, 0, 0, 1));
    tab.push_back(v(3'b001, 0, 1, 1, 0, 1));
    tab.push_back(v(3'b001, 0, 6, 1, 0, 1));
    tab.push_back(v(3'b011, 0, 3, 1, 0, 1));
    tab.push_back(v(3'b011, 0, 1, 2, 0, 1));
    tab.push_back(v(3'b011, 0, 6, 2, 0, 1));
    tab.push_back(v(3'b111, 0, 3, 2, 0, 1));
    tab.push_back(v(3'b111, 0, 1, 3, 0, 1));
    tab.push_back(v(3'b111, 0, 1, 3, 0, 0));  // valve closes one edge after full
    tab.push_back(v(3'b111, 0, 5, 3, 0, 0));
    tab.push_back(v(3'b001, 0, 4, 1, 0, 0));
    tab.push_back(v(3'b011, 0, 3, 1, 0, 0));  // 3-cycle glitch
    tab.push_back(v(3'b001, 0, 1, 1, 0, 0));
    tab.push_back(v(3'b011, 0, 3, 1, 0, 0));  // second glitch: counter was cleared
    tab.push_back(v(3'b001, 0, 5, 1, 0, 0));
    tab.push_back(v(3'b010, 0, 4, 0, 0, 0));
    tab.push_back(v(3'b010, 1, 1, 0, 1, 2));  // set wins over simultaneous ack
    tab.push_back(v(3'b010, 1, 3, 0, 1, 2));  // ack while invalid ignored
    tab.push_back(v(3'b011, 1, 3, 0, 1, 2));
    tab.push_back(v(3'b011, 1, 1, 2, 1, 2));
    tab.push_back(v(3'b011, 1, 1, 2, 0, 0));
    tab.push_back(v(3'b011, 0, 3, 2, 0, 0));

    // Reset state, including with sensors high during reset
    #12;
    verif_todos("reset", 0, 0, 0);
    Sensores = 3'b111;
    passo(2);
    verif_todos("reset_sens", 0, 0, 0);
    Sensores = 3'b000;
    passo(1);
    Rst_n = 1'b1;

    for (int i = 0; i < tab.size(); i++) begin
      Sensores = tab[i].sens;
      Ack_Erro = tab[i].ack;
      passo(tab[i].ciclos);
      verif_todos($sformatf("row%0d", i), tab[i].nivel, tab[i].erro, tab[i].estado);
    end
    Ack_Erro = 1'b0;

    // Timeout with sensors stuck at 000
    reinicia();
    passo(1);
    verif("to enter", int'(Estado), 1);
    passo(15);
    verif("to before", int'(Estado), 1);
    passo(1);
    verif_todos("to expire", 0, 0, 2);
    Ack_Erro = 1'b1;
    passo(1);
    verif("to ack", int'(Estado), 0);
    Ack_Erro = 1'b0;
    passo(1);
    verif("to refill", int'(Estado), 1);

    // Level increase at edge 10 restarts the timeout
    reinicia();
    passo(6);
    Sensores = 3'b001;
    passo(4);
    verif("rst_to nivel", int'(Nivel), 1);
    passo(7);
    verif("rst_to edge17", int'(Estado), 1);
    passo(9);
    verif("rst_to edge26", int'(Estado), 1);
    passo(1);
    verif("rst_to edge27", int'(Estado), 2);

    // Full and timeout on the same edge: full wins
    reinicia();
    passo(12);
    Sensores = 3'b111;
    passo(4);
    verif("sim nivel", int'(Nivel), 3);
    verif("sim before", int'(Estado), 1);
    passo(1);
    verif("sim full_wins", int'(Estado), 0);

    // Asynchronous reset mid-fill
    reinicia();
    Sensores = 3'b001;
    passo(6);
    verif("async fill", int'(VEntrada), 1);
    Rst_n = 1'b0;
    #2;
    verif_todos("async rst", 0, 0, 0);
    passo(1);
    Rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, erros);
    $finish;
  end

endmodule
